// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - BIN subtractor, LSB first
// Result and borrow land in DIFF/BOUT on the edge that processes the last bit.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             BIN,
   output logic [WIDTH-1:0] DIFF,
   output logic             BOUT,
   output logic             BUSY,
   output logic             DONE
);

   // Counter is wide enough to hold WIDTH so it never wraps mid-operation.
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             bit_d;
   logic             br_next;
   logic [WIDTH:0]   acc_ext;

   always_comb begin
      bit_d   = a_q[0] ^ b_q[0] ^ br_q;
      br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      acc_ext = {bit_d, acc_q};

      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      acc_d   = acc_q;
      diff_d  = diff_q;
      bout_d  = bout_q;

      case (state_q)
         IDLE: begin
            if (START) begin
               state_d = SHIFT;
               a_d     = A;
               b_d     = B;
               br_d    = BIN;
               cnt_d   = '0;
               acc_d   = '0;
            end
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_next;
            acc_d = acc_ext[WIDTH:1];
            cnt_d = cnt_q + ONE;
            if (cnt_q == LAST) begin
               state_d = FINISH;
               diff_d  = acc_ext[WIDTH:1];
               bout_d  = br_next;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         acc_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         acc_q   <= acc_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   assign DIFF = diff_q;
   assign BOUT = bout_q;
   assign BUSY = (state_q == SHIFT);
   assign DONE = (state_q == FINISH);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and swept checks of serial_subtractor, WIDTH=8
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             CLK = 1'b0;
   logic             RST;
   logic             START;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             BIN;
   logic [WIDTH-1:0] DIFF;
   logic             BOUT;
   logic             BUSY;
   logic             DONE;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .A     (A),
      .B     (B),
      .BIN   (BIN),
      .DIFF  (DIFF),
      .BOUT  (BOUT),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge with the DUT idle; returns just after a falling edge.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic [7:0] exp_d, input logic exp_b);
      int         done_at;
      int         done_cnt;
      int         busy_cnt;
      logic [7:0] d_seen;
      logic       b_seen;
      A = a;
      B = b;
      BIN = bin;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      done_at  = -1;
      done_cnt = 0;
      busy_cnt = BUSY ? 1 : 0;
      d_seen   = 'x;
      b_seen   = 1'bx;
      for (int k = 1; k <= 11; k++) begin
         @(posedge CLK);
         #1;
         if (BUSY) busy_cnt++;
         if (DONE) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = k;
               d_seen  = DIFF;
               b_seen  = BOUT;
            end
         end
      end
      check_val({tag, "_diff"}, 32'(d_seen), 32'(exp_d));
      check_val({tag, "_bout"}, 32'(b_seen), 32'(exp_b));
      check_val({tag, "_done_rise"}, done_at, 8);
      check_val({tag, "_done_fall"}, done_at + done_cnt, 9);
      check_val({tag, "_busy_cycles"}, busy_cnt, 8);
      @(negedge CLK);
   endtask

   initial begin
      int         d1;
      int         d2;
      int         dn;
      logic [7:0] r1_d;
      logic [7:0] r2_d;
      logic       r1_b;
      logic       r2_b;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rbin;
      logic [8:0] ref_v;

      // Reset held with START high: reset must win.
      RST = 1'b1;
      START = 1'b1;
      A = 8'hAA;
      B = 8'h55;
      BIN = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check_val("rst_diff", 32'(DIFF), 0);
      check_val("rst_bout", 32'(BOUT), 0);
      check_val("rst_busy", 32'(BUSY), 0);
      check_val("rst_done", 32'(DONE), 0);
      @(negedge CLK);
      RST = 1'b0;
      START = 1'b0;
      @(negedge CLK);

      run_op("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
      run_op("v00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
      run_op("v80_7f", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

      // START held high; operands change while the first operation is busy.
      A = 8'h3C;
      B = 8'h3C;
      BIN = 1'b1;
      START = 1'b1;
      @(posedge CLK);
      #1;
      d1 = -1;
      d2 = -1;
      r1_d = 'x;
      r2_d = 'x;
      r1_b = 1'bx;
      r2_b = 1'bx;
      for (int t = 1; t <= 25; t++) begin
         @(posedge CLK);
         #1;
         if (t == 2) begin
            A = 8'h10;
            B = 8'h01;
            BIN = 1'b0;
         end
         if (DONE) begin
            if (d1 < 0) begin
               d1 = t;
               r1_d = DIFF;
               r1_b = BOUT;
            end else if (d2 < 0) begin
               d2 = t;
               r2_d = DIFF;
               r2_b = BOUT;
               START = 1'b0;
            end
         end
      end
      START = 1'b0;
      check_val("hold_first_diff", 32'(r1_d), 32'h FF);
      check_val("hold_first_bout", 32'(r1_b), 1);
      check_val("hold_first_done", d1, 8);
      check_val("hold_spacing", d2 - d1, 10);
      check_val("hold_second_diff", 32'(r2_d), 32'h0F);
      check_val("hold_second_bout", 32'(r2_b), 0);
      @(negedge CLK);

      // Abort on the 4th SHIFT cycle.
      A = 8'h55;
      B = 8'h11;
      BIN = 1'b0;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check_val("abort_busy", 32'(BUSY), 0);
      check_val("abort_diff", 32'(DIFF), 0);
      check_val("abort_bout", 32'(BOUT), 0);
      @(negedge CLK);
      RST = 1'b0;
      dn = 0;
      for (int t = 0; t < 12; t++) begin
         @(posedge CLK);
         #1;
         if (DONE) dn++;
      end
      check_val("abort_no_done", dn, 0);
      check_val("abort_diff_hold", 32'(DIFF), 0);
      @(negedge CLK);

      // START on the first edge after reset release.
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      run_op("post_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         ra    = 8'($urandom);
         rb    = 8'($urandom);
         rbin  = 1'($urandom);
         ref_v = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
         run_op("rnd", ra, rb, rbin, ref_v[7:0], ref_v[8]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 1..32.
REQ-002 Port: CLK  input  1  the single clock; all state updates on the rising edge.
REQ-003 Port: RST  input  1  reset, synchronous and active-high.
REQ-004 Port: START  input  1  request a new subtraction; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  minuend, unsigned.
REQ-006 Port: B  input  WIDTH  subtrahend, unsigned.
REQ-007 Port: BIN  input  1  borrow-in.
REQ-008 Port: DIFF  output  WIDTH  registered difference.
REQ-009 Port: BOUT  output  1  registered borrow-out.
REQ-010 Port: BUSY  output  1  high while bits are being processed.
REQ-011 Port: DONE  output  1  one-cycle pulse when DIFF and BOUT become valid.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and FINISH.
REQ-013 Transition IDLE->SHIFT on a rising edge with START=1. At that edge: latch A, B and BIN into internal shift and borrow registers; clear the bit counter; clear the DIFF accumulation register.
REQ-014 Operands SHALL be captured only at acceptance; later changes on A, B or BIN SHALL have no effect on the operation in progress.
REQ-015 In SHIFT, each edge SHALL process one bit, LSB first:
  - d = a XOR b XOR br
  - br_next = (NOT a AND b) OR (NOT(a XOR b) AND br)
  - d SHALL be shifted into the result MSB-side so that after WIDTH bits it is aligned to DIFF[WIDTH-1:0].
  - The counter SHALL increment once per bit.
REQ-016 Transition SHIFT->FINISH on the edge that processes bit WIDTH-1. Exactly WIDTH SHIFT cycles SHALL occur; the counter SHALL NOT wrap within an operation.
REQ-017 Transition FINISH->IDLE unconditionally on the next edge.
REQ-018 Final result: DIFF = (A - B - BIN) mod 2^WIDTH; BOUT = 1 iff A < B + BIN, with the comparison done at full precision.
REQ-019 BUSY SHALL be 1 exactly in SHIFT.
REQ-020 DONE SHALL be 1 exactly in FINISH, for one cycle, WIDTH+1 cycles after the accepting edge.
REQ-021 DIFF and BOUT SHALL update only on entry to FINISH. They SHALL hold their values through IDLE until the next FINISH or reset.
REQ-022 START in SHIFT or FINISH SHALL be ignored and not queued. START held high continuously SHALL give one operation every WIDTH+2 cycles.
REQ-023 WIDTH=1 SHALL behave as a registered full subtractor with the same state sequence (one SHIFT cycle).

Reset
REQ-024 RST=1 at an edge SHALL force IDLE and clear DIFF, BOUT, BUSY, DONE, the counter and all internal registers to 0, regardless of state.
REQ-025 Reset SHALL take priority over START.
REQ-026 An operation aborted by reset SHALL produce no DONE pulse and no DIFF or BOUT update.
REQ-027 A START on the first edge after RST deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 A=0x05, B=0x03, BIN=0, START pulse -> BUSY high for 8 cycles, then DONE=1 for 1 cycle with DIFF=0x02, BOUT=0.
REQ-029 A=0x00, B=0x01, BIN=0 -> DIFF=0xFF, BOUT=1. Also A=0x80, B=0x7F, BIN=1 -> DIFF=0x00, BOUT=0.
REQ-030 A=0x3C, B=0x3C, BIN=1 -> DIFF=0xFF, BOUT=1. Then, with START held and operands changed to A=0x10, B=0x01 during BUSY -> the first result is unaffected and the second result, DIFF=0x0F with BOUT=0, appears exactly 10 cycles after the first DONE.
REQ-031 RST pulsed on the 4th SHIFT cycle -> on the next cycle BUSY=0, DIFF=0x00, BOUT=0, and no DONE follows. A fresh START with A=0x09, B=0x04 -> DIFF=0x05.
REQ-032 Random sweep of 1000 operand/BIN triples against a reference (A-B-BIN) model -> every DIFF and BOUT matches, and each DONE falls exactly 9 cycles after its accepting edge.
